// File: rtl/rv_regfile_sb.sv
// RV32I/RV32E integer register file: two combinational read ports, one write-back port,
// optional write-through bypass, per-register busy scoreboard, flush and illegal-register flag.
`timescale 1ns/1ps
module rv_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic            sys_clk,
    input  logic            sys_reset_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            rd_busy,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            illegal
);

    localparam int AW = $clog2(NREGS);

    function automatic logic is_legal(input logic [4:0] a);
        return ({1'b0, a} < 6'(NREGS));
    endfunction

    // A register that can actually hold state: in range and not x0.
    function automatic logic is_target(input logic [4:0] a);
        return is_legal(a) && (a != 5'd0);
    endfunction

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic [AW-1:0]    wb_idx;
    logic [AW-1:0]    iss_idx;
    logic             wb_en;
    logic             iss_en;

    assign wb_idx  = wb_rd[AW-1:0];
    assign iss_idx = issue_rd[AW-1:0];
    assign wb_en   = wb_valid && is_target(wb_rd);
    assign iss_en  = issue_valid && is_target(issue_rd);

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        busy_d = busy_q;
        if (wb_en) begin
            regs_d[wb_idx] = wb_data;
            busy_d[wb_idx] = 1'b0;
        end
        // Flush drops any reservation this cycle; otherwise a reservation overrides
        // a same-edge release because it belongs to a newer producer.
        if (flush) begin
            busy_d = '0;
        end else if (iss_en) begin
            busy_d[iss_idx] = 1'b1;
        end
        regs_d[0] = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
        end
    end

    logic [4:0]      rs_addr [2];
    logic [XLEN-1:0] rs_data [2];
    logic            rs_busy [2];

    assign rs_addr[0] = rs1_addr;
    assign rs_addr[1] = rs2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rs_data[p] = '0;
            rs_busy[p] = 1'b0;
            if (sys_reset_n && is_target(rs_addr[p])) begin
                if (BYPASS && wb_valid && (wb_rd == rs_addr[p])) begin
                    rs_data[p] = wb_data;
                    rs_busy[p] = issue_valid && (issue_rd == rs_addr[p]);
                end else begin
                    rs_data[p] = regs_q[rs_addr[p][AW-1:0]];
                    rs_busy[p] = busy_q[rs_addr[p][AW-1:0]];
                end
            end
        end
    end

    assign rs1_data = rs_data[0];
    assign rs2_data = rs_data[1];
    assign rs1_busy = rs_busy[0];
    assign rs2_busy = rs_busy[1];

    assign rd_busy = sys_reset_n && is_target(issue_rd) && busy_q[iss_idx];
    assign illegal = !is_legal(rs1_addr) || !is_legal(rs2_addr) ||
                     (issue_valid && !is_legal(issue_rd));

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Scoreboard bench for rv_regfile_sb: three configurations (RV32I+bypass, RV32I no bypass,
// RV32E+bypass) share one stimulus stream and are checked against an array-based model.
`timescale 1ns/1ps
module tb_rv_regfile_sb;

    logic        sys_clk = 1'b0;
    logic        sys_reset_n;
    logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic        issue_valid, wb_valid, flush;
    logic [31:0] wb_data;

    logic [2:0][31:0] rs1_d, rs2_d;
    logic [2:0]       rs1_b, rs2_b, rdb, ill;

    always #5 sys_clk = ~sys_clk;

    rv_regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) dut (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_d[0]), .rs2_data(rs2_d[0]),
        .rs1_busy(rs1_b[0]), .rs2_busy(rs2_b[0]),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rd_busy(rdb[0]),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .illegal(ill[0]));

    rv_regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) dut_nb (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_d[1]), .rs2_data(rs2_d[1]),
        .rs1_busy(rs1_b[1]), .rs2_busy(rs2_b[1]),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rd_busy(rdb[1]),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .illegal(ill[1]));

    rv_regfile_sb #(.XLEN(32), .NREGS(16), .BYPASS(1'b1)) dut_e (
        .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_d[2]), .rs2_data(rs2_d[2]),
        .rs1_busy(rs1_b[2]), .rs2_busy(rs2_b[2]),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .rd_busy(rdb[2]),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .illegal(ill[2]));

    typedef struct packed {
        logic [2:0][31:0] d1;
        logic [2:0][31:0] d2;
        logic [2:0]       b1;
        logic [2:0]       b2;
        logic [2:0]       rdb;
        logic [2:0]       ill;
    } exp_t;

    exp_t exp_q [$];
    int   vectors = 0;
    int   miscompares = 0;

    int          nr [3] = '{32, 32, 16};
    bit          bp [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] mem [3][32];
    bit          bsy [3][32];

    // Reference model: plain arrays indexed by register number.
    function automatic bit m_real(int c, logic [4:0] a);
        return (a != 0) && (int'(a) < nr[c]);
    endfunction

    function automatic logic [31:0] m_data(int c, logic [4:0] a);
        if (!sys_reset_n || !m_real(c, a)) return 32'h0;
        if (bp[c] && wb_valid && wb_rd == a) return wb_data;
        return mem[c][a];
    endfunction

    function automatic logic m_busy(int c, logic [4:0] a);
        if (!sys_reset_n || !m_real(c, a)) return 1'b0;
        if (bp[c] && wb_valid && wb_rd == a) return issue_valid && issue_rd == a;
        return bsy[c][a];
    endfunction

    function automatic logic m_rdb(int c);
        if (!sys_reset_n || !m_real(c, issue_rd)) return 1'b0;
        return bsy[c][issue_rd];
    endfunction

    function automatic logic m_ill(int c);
        return int'(rs1_addr) >= nr[c] || int'(rs2_addr) >= nr[c] ||
               (issue_valid && int'(issue_rd) >= nr[c]);
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 3; c++)
            for (int r = 0; r < 32; r++) begin
                mem[c][r] = 32'h0;
                bsy[c][r] = 1'b0;
            end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 3; c++) begin
            if (wb_valid && m_real(c, wb_rd)) begin
                mem[c][wb_rd] = wb_data;
                bsy[c][wb_rd] = 1'b0;
            end
            if (flush) begin
                for (int r = 0; r < 32; r++) bsy[c][r] = 1'b0;
            end else if (issue_valid && m_real(c, issue_rd)) begin
                bsy[c][issue_rd] = 1'b1;
            end
        end
    endtask

    // Inputs are stable from here until the next posedge; push expectation, then clock.
    task automatic cycle();
        exp_t e;
        if (!sys_reset_n) model_clear();
        for (int c = 0; c < 3; c++) begin
            e.d1[c]  = m_data(c, rs1_addr);
            e.d2[c]  = m_data(c, rs2_addr);
            e.b1[c]  = m_busy(c, rs1_addr);
            e.b2[c]  = m_busy(c, rs2_addr);
            e.rdb[c] = m_rdb(c);
            e.ill[c] = m_ill(c);
        end
        exp_q.push_back(e);
        @(posedge sys_clk);
        if (sys_reset_n) model_edge();
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
        issue_rd = 5'd0; wb_rd = 5'd0; wb_data = 32'h0;
    endtask

    task automatic set_wb(logic [4:0] rd, logic [31:0] d);
        wb_valid = 1'b1; wb_rd = rd; wb_data = d;
    endtask

    task automatic set_iss(logic [4:0] rd);
        issue_valid = 1'b1; issue_rd = rd;
    endtask

    task automatic chk(string name, int c, logic [31:0] act, logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s[cfg%0d] got %h expected %h at %0t", name, c, act, expv, $time);
        end
    endtask

    // Monitor: combinational outputs are presented every cycle; sample mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge sys_clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int c = 0; c < 3; c++) begin
                    chk("rs1_data", c, rs1_d[c], e.d1[c]);
                    chk("rs2_data", c, rs2_d[c], e.d2[c]);
                    chk("rs1_busy", c, 32'(rs1_b[c]), 32'(e.b1[c]));
                    chk("rs2_busy", c, 32'(rs2_b[c]), 32'(e.b2[c]));
                    chk("rd_busy",  c, 32'(rdb[c]),   32'(e.rdb[c]));
                    chk("illegal",  c, 32'(ill[c]),   32'(e.ill[c]));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1);
    end

    initial begin
        sys_reset_n = 1'b0;
        rs1_addr = 5'd1; rs2_addr = 5'd2;
        idle();
        model_clear();
        @(posedge sys_clk); #1;
        cycle();
        sys_reset_n = 1'b1;
        set_wb(5'd1, 32'hCAFE0001); rs1_addr = 5'd1;
        cycle();
        // Reset pulsed while a write-back is in flight.
        sys_reset_n = 1'b0; set_wb(5'd2, 32'h11112222); rs1_addr = 5'd2;
        cycle();
        sys_reset_n = 1'b1; idle();
        for (int a = 1; a < 32; a++) begin
            rs1_addr = 5'(a); rs2_addr = 5'(32 - a);
            cycle();
        end
        set_wb(5'd0, 32'hDEADBEEF); rs1_addr = 5'd0;
        cycle();
        idle(); cycle();
        set_wb(5'd5, 32'h12345678); rs1_addr = 5'd5;
        cycle();
        idle(); cycle();
        set_iss(5'd7);
        cycle();
        idle(); rs2_addr = 5'd7; issue_rd = 5'd7;
        cycle();
        set_wb(5'd7, 32'h000000A5);
        cycle();
        idle(); issue_rd = 5'd7;
        cycle();
        set_iss(5'd9); cycle();
        set_wb(5'd9, 32'h1); set_iss(5'd9); rs1_addr = 5'd9;
        cycle();
        idle(); issue_rd = 5'd9;
        cycle();
        set_iss(5'd3); cycle();
        set_iss(5'd4); cycle();
        set_iss(5'd5); cycle();
        flush = 1'b1; set_iss(5'd6); set_wb(5'd3, 32'h77); rs1_addr = 5'd3; rs2_addr = 5'd6;
        cycle();
        idle(); rs1_addr = 5'd3; rs2_addr = 5'd4; issue_rd = 5'd5;
        cycle();
        rs2_addr = 5'd6; issue_rd = 5'd6;
        cycle();
        rs1_addr = 5'd20; rs2_addr = 5'd1;
        cycle();
        set_wb(5'd20, 32'h20202020); cycle();
        idle(); set_iss(5'd17); cycle();
        idle(); rs1_addr = 5'd20; rs2_addr = 5'd17; issue_rd = 5'd17;
        cycle();

        for (int n = 0; n < 2000; n++) begin
            rs1_addr    = 5'($urandom_range(0, 31));
            rs2_addr    = 5'($urandom_range(0, 31));
            issue_valid = 1'($urandom_range(0, 1));
            issue_rd    = 5'($urandom_range(0, 31));
            wb_valid    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: wb_rd = rs1_addr;
                1: wb_rd = rs2_addr;
                2: wb_rd = issue_rd;
                default: wb_rd = 5'($urandom_range(0, 31));
            endcase
            wb_data     = $urandom;
            flush       = ($urandom_range(0, 31) == 0);
            sys_reset_n = ($urandom_range(0, 255) != 0);
            cycle();
        end
        sys_reset_n = 1'b1;
        idle();
        cycle();

        @(negedge sys_clk); #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv_regfile_sb.md
Name: rv_regfile_sb

Overview:
Parametrised integer register file for RV32I/RV32E cores, with two combinational read ports and one write-back port. Adds features the base register file lacks: write-through bypass, a per-register busy scoreboard (reserve at issue, release at write-back), a pipeline flush, and an illegal-register flag for reduced register counts. Sits between decode/issue (read, reserve) and the write-back stage.

Parameters:
XLEN, 32, data width of every register in bits.
NREGS, 32, number of architectural registers; legal values are 16 (RV32E) and 32.
BYPASS, 1, when 1, same-cycle write-back data is forwarded to the read ports.

Ports:
sys_clk  in  1  clock; all state changes on the rising edge
sys_reset_n  in  1  asynchronous reset, active-low
rs1_addr  in  5  read port 1 address
rs2_addr  in  5  read port 2 address
rs1_data  out  XLEN  read port 1 data (combinational)
rs2_data  out  XLEN  read port 2 data (combinational)
rs1_busy  out  1  rs1 has an outstanding producer
rs2_busy  out  1  rs2 has an outstanding producer
issue_valid  in  1  reserve issue_rd this cycle
issue_rd  in  5  destination register to mark busy
rd_busy  out  1  issue_rd is already busy (WAW check, combinational)
wb_valid  in  1  write-back strobe
wb_rd  in  5  write-back destination
wb_data  in  XLEN  write-back data
flush  in  1  clear all busy bits
illegal  out  1  any of rs1_addr, rs2_addr, or issue_rd (when issue_valid) is >= NREGS

Behaviour:
- Reset (sys_reset_n=0): asynchronously and immediately clears all registers and all busy bits; this also applies mid-operation. Read data and busy outputs are 0 while reset is held.
- x0 hardwired to zero:
  - Reads return 0 and busy 0.
  - wb and issue targeting x0 are ignored.
- Out-of-range address (>= NREGS):
  - Reads return 0 and busy 0.
  - Writes and reservations are ignored.
  - illegal=1 combinationally. With NREGS=32, illegal is constant 0.
- Write: at the posedge where wb_valid=1 and wb_rd is legal and non-zero, the register takes wb_data and its busy bit is cleared. The value is visible on the read ports from the next cycle, or in the same cycle when BYPASS=1.
- Bypass (BYPASS=1): if wb_valid=1 and wb_rd==rsN_addr (rsN_addr non-zero and legal):
  - rsN_data = wb_data
  - rsN_busy = 0, unless issue_valid with issue_rd==rsN_addr in the same cycle; reservation does not affect read data.
- Bypass (BYPASS=0): reads return stored contents and rsN_busy = the stored busy bit.
- Reserve: at the posedge where issue_valid=1 and issue_rd is legal and non-zero, busy[issue_rd] is set. rd_busy = busy[issue_rd] (stored bit, no bypass).
- Simultaneous events at the same posedge:
  - Reserve and release of the same register: data is written and busy ends at 1 (reserve wins; newer producer).
  - flush=1: all busy bits are cleared; a concurrent issue reservation is dropped; a concurrent write-back still writes data.
- Latency: reads are 0 cycles (combinational); writes and busy updates take effect 1 cycle after the edge, except where bypass applies.
- No state beyond NREGS x XLEN data plus NREGS busy bits. Bit 0 is tied to 0.

Test Plan:
- Reset and zero register: pulse sys_reset_n low mid-write; release; read x1..x31 -> all 0, all busy 0. Then wb x0<=0xDEADBEEF -> rs1_addr=0 reads 0.
- Write/read with bypass: wb x5<=0x12345678 with rs1_addr=5 in the same cycle -> rs1_data=0x12345678 that cycle (BYPASS=1). With BYPASS=0 the old value 0 is read that cycle and 0x12345678 on the next.
- Scoreboard: issue x7 -> next cycle rs2_addr=7 gives rs2_busy=1 and rd_busy=1. Then wb x7<=0xA5 -> busy 0 in the wb cycle (bypass) and stored busy 0 afterwards.
- Reserve/release collision: x9 busy; same edge wb x9<=0x1 and issue x9 -> x9=0x1 and busy stays 1.
- Flush: set busy on x3/x4/x5, then flush together with issue x6 and wb x3<=0x77 -> all busy 0 (x6 not reserved) and x3=0x77.
- RV32E (NREGS=16): rs1_addr=20 -> rs1_data=0, illegal=1. wb x20 ignored. issue x17 with issue_valid -> illegal=1 and no busy bit set.
